// File: rtl/sfi_arbiter.sv
// ----------------------------------------------------------------------------
// sfi_arbiter : two-requester round-robin arbiter that rewrites store tag bytes
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sfi_arbiter #(
  parameter logic [7:0] SANDBOX_TAG = 8'hA2,
  parameter int         CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in0_valid,
  input  logic [63:0]      in0_data,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [63:0]      in1_data,
  output logic             in1_ready,
  output logic             out_valid,
  output logic [63:0]      out_data,
  output logic             out_src,
  input  logic             out_ready,
  input  logic             tag_we,
  input  logic [7:0]       tag_wdata,
  output logic [7:0]       tag,
  output logic             busy,
  output logic [CNT_W-1:0] store_cnt0,
  output logic [CNT_W-1:0] store_cnt1,
  output logic [CNT_W-1:0] fix_cnt
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_UPDATE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t             state_q, state_d;
  logic               last_q, last_d;
  logic               out_valid_q, out_valid_d;
  logic [63:0]        out_data_q, out_data_d;
  logic               out_src_q, out_src_d;
  logic [7:0]         tag_q, tag_d;
  logic [7:0]         pend_q, pend_d;
  logic [CNT_W-1:0]   cnt0_q, cnt0_d;
  logic [CNT_W-1:0]   cnt1_q, cnt1_d;
  logic [CNT_W-1:0]   fix_q, fix_d;

  logic               can_accept;
  logic               grant0, grant1, accept;
  logic [63:0]        acc_data;
  logic               acc_store;

  function automatic logic is_store(input logic [5:0] op);
    case (op)
      6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2C, 6'h2D, 6'h2E,
      6'h38, 6'h3C, 6'h3F: is_store = 1'b1;
      default:             is_store = 1'b0;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // Grant: requester 0 wins unless requester 1 is also valid and 0 was served last.
  always_comb begin
    can_accept = !out_valid_q || out_ready;
    grant0     = 1'b0;
    grant1     = 1'b0;
    if (state_q == ST_RUN && can_accept) begin
      if (in0_valid && (!in1_valid || last_q)) begin
        grant0 = 1'b1;
      end else if (in1_valid) begin
        grant1 = 1'b1;
      end
    end
    accept    = grant0 | grant1;
    acc_data  = grant1 ? in1_data : in0_data;
    acc_store = is_store(acc_data[31:26]);
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    tag_d       = tag_q;
    pend_d      = pend_q;
    cnt0_d      = cnt0_q;
    cnt1_d      = cnt1_q;
    fix_d       = fix_q;

    if (accept) begin
      out_valid_d = 1'b1;
      out_data_d  = acc_store ? {tag_q, acc_data[55:0]} : acc_data;
      out_src_d   = grant1;
      last_d      = grant1;
      if (acc_store) begin
        if (grant1) cnt1_d = sat_inc(cnt1_q);
        else        cnt0_d = sat_inc(cnt0_q);
        if (acc_data[63:56] != tag_q) fix_d = sat_inc(fix_q);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    // A tag change waits for the output register to empty so no pair mixes tags.
    case (state_q)
      ST_RUN: begin
        if (tag_we) begin
          pend_d  = tag_wdata;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!out_valid_q || out_ready) state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        tag_d   = pend_q;
        state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      last_q      <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= 64'd0;
      out_src_q   <= 1'b0;
      tag_q       <= SANDBOX_TAG;
      pend_q      <= 8'd0;
      cnt0_q      <= '0;
      cnt1_q      <= '0;
      fix_q       <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      tag_q       <= tag_d;
      pend_q      <= pend_d;
      cnt0_q      <= cnt0_d;
      cnt1_q      <= cnt1_d;
      fix_q       <= fix_d;
    end
  end

  assign in0_ready  = grant0;
  assign in1_ready  = grant1;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_src    = out_src_q;
  assign tag        = tag_q;
  assign busy       = (state_q != ST_RUN);
  assign store_cnt0 = cnt0_q;
  assign store_cnt1 = cnt1_q;
  assign fix_cnt    = fix_q;

endmodule

`default_nettype wire

// File: doc/sfi_arbiter.md
SFI_ARBITER -- requirements
Module: sfi_arbiter

Interface
REQ-001 Parameter SANDBOX_TAG, default 8'hA2, reset value of the sandbox tag register.
REQ-002 Parameter CNT_W, default 16, width of each statistics counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in0_valid / in1_valid  input  1 each  requester 0 / 1 offers an instruction pair.
REQ-006 in0_data / in1_data  input  64 each  requester pair; [63:32] address-forming word, [31:0] memory instruction.
REQ-007 in0_ready / in1_ready  output  1 each  pair accepted this cycle when ready and valid are both high.
REQ-008 out_valid  output  1  output register holds a rewritten pair.
REQ-009 out_data  output  64  rewritten pair.
REQ-010 out_src  output  1  index of the requester that supplied out_data.
REQ-011 out_ready  input  1  consumer takes out_data when out_valid and out_ready are both high.
REQ-012 tag_we  input  1  request to replace the sandbox tag; single-cycle pulse.
REQ-013 tag_wdata  input  8  new sandbox tag.
REQ-014 tag  output  8  current sandbox tag.
REQ-015 busy  output  1  high while a tag update is pending.
REQ-016 store_cnt0 / store_cnt1  output  CNT_W each  per-requester count of accepted store pairs.
REQ-017 fix_cnt  output  CNT_W  count of accepted pairs whose tag byte was changed.

Function
REQ-018 Store detect: the pair is a store iff data[31:26] is in {0x28,0x29,0x2A,0x2B,0x2C,0x2D,0x2E,0x38,0x3C,0x3F}.
REQ-019 Rewrite for a store: [63:56] = tag; [55:0] passes unchanged.
REQ-020 Rewrite for a non-store: all 64 bits pass unchanged.
REQ-021 The output register can accept when out_valid is low, or when out_valid and out_ready are both high (same-cycle drain and refill).
REQ-022 At most one requester is granted per cycle; no ready is asserted in state DRAIN or UPDATE.
REQ-023 Round-robin arbitration: a single valid requester is granted; when both are valid, the requester not served last is granted.
REQ-024 The last-served pointer resets to 1, so requester 0 wins the first contention.
REQ-025 in*_ready is combinational from valid, the pointer, state and the accept condition.
REQ-026 On accept, out_data, out_src and out_valid=1 are registered on the next edge; latency is 1 cycle.
REQ-027 out_valid/out_data/out_src are held stable until taken; out_valid clears after a take with no refill.
REQ-028 On accept of a store from requester i, store_cnt_i increments.
REQ-029 On accept of a store whose input [63:56] is not equal to tag, fix_cnt increments.
REQ-030 All counters saturate at all-ones and do not wrap.
REQ-031 FSM states: RUN, DRAIN, UPDATE.
REQ-032 RUN: on tag_we, latch tag_wdata into a pending register and go to DRAIN; an accept in that same cycle completes using the old tag.
REQ-033 DRAIN: busy=1; leave for UPDATE once out_valid is 0 (including after a take this cycle).
REQ-034 UPDATE: busy=1; tag is loaded from the pending register; return to RUN next cycle.
REQ-035 tag_we outside RUN is ignored; the first pending value wins.
REQ-036 Every rewrite uses the tag value registered at the accept edge; no pair observes a partially updated tag.

Reset
REQ-037 While rst_n is low: out_valid=0, out_data=0, out_src=0, busy=0, state=RUN, tag=SANDBOX_TAG, all counters 0, pointer=1.
REQ-038 An in-flight pair, pending tag, or DRAIN state is discarded on reset.
REQ-039 The first accept can occur in the first cycle after rst_n deasserts.

Verification
REQ-040 Requester 0 only, in0_data=64'hFAFA0000A0111111, out_ready=1 -> out_data=64'hA2FA0000A0111111 next cycle; store_cnt0=1; fix_cnt=1.
REQ-041 Requester 1 only, in1_data=64'h0123456789ABCDEF -> out_data is unchanged; store_cnt1=0; fix_cnt=0.
REQ-042 Requester 1 only, in1_data=64'hA2CAFE06A4111111 -> out_data is unchanged; store_cnt1=1; fix_cnt=0.
REQ-043 Both requesters valid for 4 cycles, out_ready=1 -> out_src sequence 0,1,0,1; 4 pairs in 4 cycles.
REQ-044 out_ready=0 for 3 cycles with both requesters valid -> out_data stable; both in*_ready drop after the first accept; no loss or duplication.
REQ-045 tag_we with tag_wdata=8'hC0 while out_valid=1 and out_ready is held low 2 cycles -> busy=1, no accepts, tag=8'hC0 after UPDATE; next store 64'h00000008A8111111 -> 64'hC0000008A8111111.
